xintf_bus_master: RTL
=====================

Name: xintf_bus_master

Overview:
- Initiator end of the DSP external-bus protocol used by the bypass FPGA, replacing the DSP on bench rigs and on the board-to-board link.
- Generates chip-select, address, read-strobe and write-strobe cycles with programmable setup, strobe and hold timing.
- Watches the responder's interrupt line; on each rising edge it automatically reads the status register.
- Exposes a simple valid/ready request port and a response port to local logic.

Parameters:
- SETUP_CYC, 2, clocks with chip-select and address valid before the strobe falls (legal range 1..255).
- STROBE_CYC, 4, clocks the read or write strobe is held low (1..255).
- HOLD_CYC, 2, clocks chip-select, address and write data are held after the strobe rises (1..255).
- STATUS_ADDR, 4'h1, address read automatically when an interrupt is serviced.

Ports:
- CLK  in  1  system clock, 50 MHz
- RST  in  1  synchronous active-high reset
- req_valid  in  1  transaction request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  4  target address
- req_wdata  in  8  write data
- req_ready  out  1  request accepted when high together with req_valid
- rsp_valid  out  1  one-clock completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid
- INT1  in  1  responder interrupt, asynchronous
- status_valid  out  1  one-clock pulse when an auto status read completes
- status_data  out  7  bits [6:0] of the status read
- XA  out  4  bus address
- XZCS7n  out  1  chip select, active low
- XRDn  out  1  read strobe, active low
- XWE0n  out  1  write strobe, active low
- XD  inout  8  bidirectional data bus

Behaviour:
- Reset values (all outputs): XZCS7n=1, XRDn=1, XWE0n=1, XA=0, XD=Z, req_ready=0 during RST, rsp_valid=0, rsp_rdata=0, status_valid=0, status_data=0.
- Reset also clears the FSM, the interrupt pending flag and both INT1 synchronizer flops.
- All bus outputs are registered.
- FSM states: IDLE, SETUP, STROBE, HOLD. A single 8-bit down-counter times each phase.
- IDLE:
  - Bus idle; XD=Z.
  - req_ready = IDLE & ~int_pending & ~int_edge.
  - If int_pending or int_edge: start an internal read of STATUS_ADDR; the request port is held off.
  - Else if req_valid: latch req_wr, req_addr and req_wdata.
  - Either way the next state is SETUP.
- SETUP (SETUP_CYC clocks): XZCS7n=0, XA=address, strobes high. For a write, XD is driven from the first SETUP clock.
- STROBE (STROBE_CYC clocks):
  - The read asserts XRDn=0; the write asserts XWE0n=0.
  - Read data is sampled from XD on the last STROBE clock edge, i.e. the edge on which XRDn returns high.
- HOLD (HOLD_CYC clocks):
  - Strobes high, XZCS7n=0, XA held; write data stays driven so the responder latches it on the rising edge of XWE0n.
  - XD is released on the transition to IDLE.
- Completion: in the first IDLE clock after HOLD, exactly one of the following pulses for one clock.
  - User transaction: rsp_valid; read data appears on rsp_rdata. For a write, rsp_rdata is unchanged.
  - Auto status read: status_valid; status_data = sampled XD[6:0]. rsp_valid is not pulsed.
- Bus cycle length is SETUP_CYC+STROBE_CYC+HOLD_CYC clocks with chip-select low.
- With defaults:
  - A request accepted on edge T drives XZCS7n low from T+1.
  - rsp_valid is asserted in cycle T+9.
  - The next request can be accepted at T+9.
- Parameter value 0 is treated as 1.
- Interrupt handling:
  - INT1 passes through a 2-flop synchronizer; a rising edge of the synchronized signal is int_edge.
  - int_edge sets int_pending; int_pending is cleared when the status read enters SETUP.
  - Edges arriving while pending, or during a user transaction, coalesce into a single pending flag.
  - An edge arriving during a status read sets pending again, so another status read follows.
- Simultaneous req_valid and int_edge in IDLE: the interrupt wins, req_ready=0 and the request waits.
- The XD driver is never enabled while XRDn=0.
- The XD driver is never enabled in the same cycle XZCS7n rises.
- Reset mid-transaction: all bus outputs return to their idle values on the next clock.
  - If reset hits during a write STROBE, XWE0n rises while XD is released.
  - The responder may then latch undefined data; the controller must rewrite the register after reset.
- XA is not changed while XZCS7n=0.

Test Plan:
- Write, defaults: req_wr=1, addr 0, wdata 8'h05, accepted at T → XZCS7n low T+1..T+8, XWE0n low T+3..T+6, XD=8'h05 T+1..T+8, rsp_valid at T+9, Z afterwards.
- Read: responder model drives 8'h5A while XRDn low, addr 1 → XRDn low for exactly 4 clocks, rsp_rdata=8'h5A with rsp_valid at T+9.
- Interrupt: INT1 rising edge while idle; model returns 7'h2C on addr 1 → auto read of XA=1 within 4 clocks, status_valid pulse with status_data=7'h2C, no rsp_valid.
- Collision: INT1 edge during a user read, then req_valid held → read completes first, status read second, queued request accepted third; three INT1 edges inside one transaction produce exactly one status read.
- Timing parameters SETUP_CYC=1, STROBE_CYC=10, HOLD_CYC=3 → total 14 chip-select clocks, strobe low 10, rsp_valid at T+15.
- Reset asserted in the middle of a write STROBE → next clock XZCS7n=XRDn=XWE0n=1, XD=Z, no rsp_valid; a following read completes normally.

Source files
------------

// File: rtl/xintf_bus_master_if.sv
// Request/response and external-bus signals of the DSP external-bus initiator.
// The bidirectional data bus XD stays a plain module port.
interface xintf_bus_master_if;
  logic       req_valid;
  logic       req_wr;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       INT1;
  logic       status_valid;
  logic [6:0] status_data;
  logic [3:0] XA;
  logic       XZCS7n;
  logic       XRDn;
  logic       XWE0n;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, INT1,
    output req_ready, rsp_valid, rsp_rdata, status_valid, status_data,
           XA, XZCS7n, XRDn, XWE0n
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, INT1,
    input  req_ready, rsp_valid, rsp_rdata, status_valid, status_data,
           XA, XZCS7n, XRDn, XWE0n
  );
endinterface

// File: rtl/xintf_bus_master.sv
// DSP external-bus initiator: timed CS/RD/WE cycles for local requests, plus an
// automatic status-register read on every rising edge of the responder interrupt.
module xintf_bus_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter logic [3:0]  STATUS_ADDR = 4'h1
) (
  input  logic               CLK,
  input  logic               RST,
  xintf_bus_master_if.master bus,
  inout  wire  [7:0]         XD
);

  // Phase counters count down to zero; a parameter of 0 behaves like 1.
  localparam logic [7:0] SETUP_LD  = (SETUP_CYC  > 1) ? 8'(SETUP_CYC  - 1) : 8'd0;
  localparam logic [7:0] STROBE_LD = (STROBE_CYC > 1) ? 8'(STROBE_CYC - 1) : 8'd0;
  localparam logic [7:0] HOLD_LD   = (HOLD_CYC   > 1) ? 8'(HOLD_CYC   - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] int_sync;     // [0],[1] synchronizer, [2] previous synchronized value
  logic       int_pending;
  logic       int_edge;
  logic       cur_wr;
  logic       cur_status;
  logic       xd_oe;
  logic [7:0] xd_out;
  logic [7:0] sample;

  assign int_edge      = int_sync[1] & ~int_sync[2];
  assign XD            = xd_oe ? xd_out : 'z;
  assign bus.req_ready = ~RST & (state == IDLE) & ~int_pending & ~int_edge;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      cnt              <= '0;
      int_sync         <= '0;
      int_pending      <= 1'b0;
      cur_wr           <= 1'b0;
      cur_status       <= 1'b0;
      xd_oe            <= 1'b0;
      xd_out           <= '0;
      sample           <= '0;
      bus.XA           <= '0;
      bus.XZCS7n       <= 1'b1;
      bus.XRDn         <= 1'b1;
      bus.XWE0n        <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.status_valid <= 1'b0;
      bus.status_data  <= '0;
    end else begin
      int_sync         <= {int_sync[1:0], bus.INT1};
      bus.rsp_valid    <= 1'b0;
      bus.status_valid <= 1'b0;
      if (int_edge) int_pending <= 1'b1;

      unique case (state)
        IDLE: begin
          // The interrupt has priority; its pending flag is consumed as the status read starts.
          if (int_pending || int_edge) begin
            cur_status  <= 1'b1;
            cur_wr      <= 1'b0;
            xd_oe       <= 1'b0;
            bus.XA      <= STATUS_ADDR;
            int_pending <= 1'b0;
            bus.XZCS7n  <= 1'b0;
            cnt         <= SETUP_LD;
            state       <= SETUP;
          end else if (bus.req_valid) begin
            cur_status <= 1'b0;
            cur_wr     <= bus.req_wr;
            xd_oe      <= bus.req_wr;
            xd_out     <= bus.req_wdata;
            bus.XA     <= bus.req_addr;
            bus.XZCS7n <= 1'b0;
            cnt        <= SETUP_LD;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            if (cur_wr) bus.XWE0n <= 1'b0;
            else        bus.XRDn  <= 1'b0;
            cnt   <= STROBE_LD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            bus.XRDn  <= 1'b1;
            bus.XWE0n <= 1'b1;
            if (!cur_wr) sample <= XD;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            bus.XZCS7n <= 1'b1;
            xd_oe      <= 1'b0;
            state      <= IDLE;
            if (cur_status) begin
              bus.status_valid <= 1'b1;
              bus.status_data  <= sample[6:0];
            end else begin
              bus.rsp_valid <= 1'b1;
              if (!cur_wr) bus.rsp_rdata <= sample;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
